// File: rtl/second_pulse_gen.sv
// One-second tick generator: divides clk by N (CLK_HZ, or FAST_DIV in fast mode) into a
// one-cycle pulse, a 50 % blink square wave and a wrapping seconds counter.
module second_pulse_gen #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned FAST_DIV = 10,
  parameter int unsigned MAX_SEC  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fast,
  input  logic       sync_clear,
  output logic       pulse_1s,
  output logic       blink,
  output logic [5:0] sec_count
);

  localparam int unsigned CntW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  localparam logic [CntW-1:0] FullTop  = CntW'(CLK_HZ - 1);
  localparam logic [CntW-1:0] FastTop  = CntW'(FAST_DIV - 1);
  localparam logic [CntW-1:0] FullHalf = CntW'(CLK_HZ / 2 - 1);
  localparam logic [CntW-1:0] FastHalf = CntW'(FAST_DIV / 2 - 1);
  localparam logic [5:0]      SecTop   = 6'(MAX_SEC);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic            pulse_q, pulse_d;
  logic            blink_q, blink_d;
  logic [5:0]      sec_q, sec_d;

  logic [CntW-1:0] top;
  logic [CntW-1:0] half;
  logic            wrap;

  assign top  = fast ? FastTop : FullTop;
  assign half = fast ? FastHalf : FullHalf;
  // >= so a switch into fast mode past the short terminal count wraps at once.
  assign wrap = (div_cnt_q >= top);

  always_comb begin
    div_cnt_d = div_cnt_q;
    pulse_d   = 1'b0;
    blink_d   = blink_q;
    sec_d     = sec_q;
    if (sync_clear) begin
      div_cnt_d = '0;
      blink_d   = 1'b0;
      sec_d     = '0;
    end else if (en) begin
      if (wrap) begin
        div_cnt_d = '0;
        pulse_d   = 1'b1;
        blink_d   = 1'b1;
        sec_d     = (sec_q == SecTop) ? 6'd0 : sec_q + 6'd1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == half) begin
          blink_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      pulse_q   <= 1'b0;
      blink_q   <= 1'b0;
      sec_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pulse_q   <= pulse_d;
      blink_q   <= blink_d;
      sec_q     <= sec_d;
    end
  end

  assign pulse_1s  = pulse_q;
  assign blink     = blink_q;
  assign sec_count = sec_q;

endmodule

// File: tb/tb_second_pulse_gen.sv
// Bench for second_pulse_gen: hand-written vector table, directed corner sequences and
// randomized traffic checked against a behavioural divider model.
module tb_second_pulse_gen;

  localparam int unsigned ClkHz   = 1000;
  localparam int unsigned FastDiv = 10;
  localparam int unsigned MaxSec  = 59;

  logic       clk;
  logic       rst, en, fast, sync_clear;
  logic       pulse_1s, blink;
  logic [5:0] sec_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Behavioural model state
  int m_cnt, m_sec;
  bit m_pulse, m_blink;

  second_pulse_gen #(
    .CLK_HZ  (ClkHz),
    .FAST_DIV(FastDiv),
    .MAX_SEC (MaxSec)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fast      (fast),
    .sync_clear(sync_clear),
    .pulse_1s  (pulse_1s),
    .blink     (blink),
    .sec_count (sec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit r, e, f, sc;
    bit exp_pulse, exp_blink;
    int exp_sec;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One period of N cycles: wrap after N enabled edges, blink high for the first half.
  task automatic model_step(input bit r, input bit e, input bit f, input bit sc);
    int n;
    n = f ? FastDiv : ClkHz;
    m_pulse = 1'b0;
    if (r || sc) begin
      m_cnt = 0; m_sec = 0; m_blink = 1'b0;
    end else if (e) begin
      if (m_cnt >= n - 1) begin
        m_cnt   = 0;
        m_pulse = 1'b1;
        m_blink = 1'b1;
        m_sec   = (m_sec + 1) % (MaxSec + 1);
      end else begin
        if (m_cnt == n / 2 - 1) m_blink = 1'b0;
        m_cnt++;
      end
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit f, input bit sc, input bit chk);
    rst = r; en = e; fast = f; sync_clear = sc;
    @(posedge clk);
    model_step(r, e, f, sc);
    #1;
    if (chk) begin
      check("model_pulse", int'(pulse_1s), int'(m_pulse));
      check("model_blink", int'(blink), int'(m_blink));
      check("model_sec", int'(sec_count), m_sec);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fast = 1'b0; sync_clear = 1'b0;

    // Vector table: reset, first two fast periods, sync_clear, mid-run reset.
    tbl[0] = '{1, 0, 1, 0, 0, 0, 0};
    for (int i = 1; i <= 9; i++)   tbl[i] = '{0, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 1, 1, 1};
    for (int i = 11; i <= 14; i++) tbl[i] = '{0, 1, 1, 0, 0, 1, 1};
    for (int i = 15; i <= 19; i++) tbl[i] = '{0, 1, 1, 0, 0, 0, 1};
    tbl[20] = '{0, 1, 1, 0, 1, 1, 2};
    tbl[21] = '{0, 1, 1, 1, 0, 0, 0};
    tbl[22] = '{0, 1, 1, 0, 0, 0, 0};
    tbl[23] = '{1, 1, 1, 0, 0, 0, 0};

    for (int i = 0; i < 24; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].sc, 1'b0);
      check($sformatf("tbl%0d_pulse", i), int'(pulse_1s), int'(tbl[i].exp_pulse));
      check($sformatf("tbl%0d_blink", i), int'(blink), int'(tbl[i].exp_blink));
      check($sformatf("tbl%0d_sec", i), int'(sec_count), tbl[i].exp_sec);
    end

    // Seconds wrap MAX_SEC -> 0 with the pulse still emitted.
    tick(1, 0, 1, 0, 1'b0);
    repeat (580) tick(0, 1, 1, 0, 1'b0);
    check("secwrap_58", int'(sec_count), 58);
    repeat (10) tick(0, 1, 1, 0, 1'b0);
    check("secwrap_59", int'(sec_count), 59);
    repeat (10) tick(0, 1, 1, 0, 1'b0);
    check("secwrap_0", int'(sec_count), 0);
    check("secwrap_pulse", int'(pulse_1s), 1);

    // en dropped for 7 cycles at div_cnt=4 delays the pulse by 7 cycles.
    tick(1, 0, 1, 0, 1'b0);
    repeat (4) tick(0, 1, 1, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(0, 0, 1, 0, 1'b0);
      check("hold_nopulse", int'(pulse_1s), 0);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(0, 1, 1, 0, 1'b0);
      check($sformatf("hold_resume%0d", i), int'(pulse_1s), (i == 6) ? 1 : 0);
    end

    // Switching into fast mode past the short terminal count wraps immediately.
    tick(1, 0, 0, 0, 1'b0);
    repeat (500) tick(0, 1, 0, 0, 1'b0);
    check("slow_nopulse", int'(pulse_1s), 0);
    tick(0, 1, 1, 0, 1'b0);
    check("fastsw_pulse", int'(pulse_1s), 1);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 1, 0, 1'b0);
      check($sformatf("fastsw_next%0d", i), int'(pulse_1s), (i == 10) ? 1 : 0);
    end

    // sync_clear on the wrap edge suppresses the pulse and increment.
    tick(1, 0, 1, 0, 1'b0);
    repeat (9) tick(0, 1, 1, 0, 1'b0);
    tick(0, 1, 1, 1, 1'b0);
    check("sclr_pulse", int'(pulse_1s), 0);
    check("sclr_sec", int'(sec_count), 0);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 1, 0, 1'b0);
      check($sformatf("sclr_next%0d", i), int'(pulse_1s), (i == 10) ? 1 : 0);
    end
    check("sclr_sec1", int'(sec_count), 1);

    // Reset mid-period with sec_count=5 and blink high.
    tick(1, 0, 1, 0, 1'b0);
    repeat (52) tick(0, 1, 1, 0, 1'b0);
    check("pre_rst_sec", int'(sec_count), 5);
    check("pre_rst_blink", int'(blink), 1);
    tick(1, 1, 1, 0, 1'b0);
    check("midrst_pulse", int'(pulse_1s), 0);
    check("midrst_blink", int'(blink), 0);
    check("midrst_sec", int'(sec_count), 0);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 1, 0, 1'b0);
      check($sformatf("midrst_next%0d", i), int'(pulse_1s), (i == 10) ? 1 : 0);
    end

    // Randomized traffic against the model.
    begin
      bit f;
      f = 1'b1;
      tick(1, 0, f, 0, 1'b1);
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(99) == 0) f = ~f;
        tick(($urandom_range(999) == 0), ($urandom_range(3) != 0), f,
             ($urandom_range(299) == 0), 1'b1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
